bpsk_integrate_dump: RTL and testbench
======================================

// Module: bpsk_integrate_dump
// PURPOSE
//   Receiver front stage directly downstream of the AWGN channel model.
//   Consumes noisy 16-bit two's-complement channel samples, integrates
//   SAMPLES_PER_SYM samples per symbol and dumps a hard BPSK decision
//   (sign of sum) onto a valid/ready bit stream for the decoder.
//   Symbol timing is set by an external sym_start marker from the bench/TX.
// PARAMETERS
//   DATA_W          16  sample width, signed two's complement
//   SAMPLES_PER_SYM 8   samples per symbol, >=2; ACC_W = DATA_W+$clog2(SPS)
// PORTS
//   clk          in   1       system clock, all logic on rising edge
//   reset        in   1       synchronous, active-high
//   signal_in    in   DATA_W  channel sample (signed), qualified by sample_valid
//   sample_valid in   1       signal_in valid this cycle
//   sym_start    in   1       with sample_valid: this sample is first of a symbol
//   clear_err    in   1       clears sticky error flags
//   bit_out      out  1       hard decision: 1 if sum>=0, 0 if sum<0
//   bit_valid    out  1       bit_out valid; held until bit_ready
//   bit_ready    in   1       downstream accepts bit_out when bit_valid&bit_ready
//   overflow_err out  1       sticky: decision dropped due to backpressure
//   resync_err   out  1       sticky: sym_start arrived mid-symbol
// BEHAVIOUR
//   - Reset (sync, all regs): state=WAIT_ALIGN, acc=0, cnt=0, bit_out=0,
//     bit_valid=0, overflow_err=0, resync_err=0 (soft_out=0 if enabled).
//   - FSM WAIT_ALIGN: ignore samples until sample_valid&sym_start; that
//     sample loads acc=sext(signal_in), cnt=1, -> INTEGRATE.
//   - INTEGRATE, per sample_valid (no-op cycles when sample_valid=0):
//       sym_start=0, cnt<SPS-1 : acc+=sext(signal_in), cnt++.
//       sym_start=0, cnt==SPS-1: sum=acc+sext(signal_in) -> dump; acc=0,
//         cnt=0, stay INTEGRATE (next sample starts next symbol, no marker
//         needed).
//       sym_start=1, cnt==0    : normal symbol start, accumulate.
//       sym_start=1, cnt!=0    : discard partial acc, resync_err<=1,
//         acc=sext(signal_in), cnt=1 (this sample is first of new symbol).
//   - Arithmetic: ACC_W-bit signed, cannot overflow for SPS full-scale
//     samples; no rounding. Decision = ~sum[ACC_W-1]; sum==0 -> 1.
//   - Latency: bit_valid rises cycle after the last sample of symbol.
//   - Output register (1-deep), on a dump cycle:
//       bit_valid=0, or bit_valid&bit_ready: load bit_out, bit_valid=1.
//       bit_valid&~bit_ready: keep held bit, drop new, overflow_err<=1.
//     Non-dump cycle: bit_valid&bit_ready -> bit_valid=0.
//   - bit_out/soft_out stable while bit_valid&~bit_ready.
//   - clear_err clears both stickies; if same cycle sets a flag, set wins.
//   - reset mid-symbol: partial sum lost, pending bit dropped, WAIT_ALIGN.
// CONFIGURATION
//   IAD_SOFT_OUT_EN defined: adds port soft_out out DATA_W, the dumped sum
//     saturated to signed DATA_W range, loaded/held with bit_out, reset 0.
//   Not defined: no soft_out port and no saturation logic; hard bit only.
// TESTING (SPS=8, DATA_W=16)
//   1) reset, sym_start+8 samples of +1000, ready=1 -> bit_out=1, bit_valid
//      1 cycle after 8th sample for 1 cycle; soft_out=8000.
//   2) 8 samples of -1000 then 4 of +500,4 of -500 (sum 0) -> bits 0 then 1.
//   3) IAD_SOFT_OUT_EN, 8x +32767 -> soft_out=32767; 8x -32768 -> -32768.
//   4) ready=0, two symbols +/-: first bit held, second dropped,
//      overflow_err=1; clear_err -> 0; ready=1 -> first bit accepted.
//   5) sym_start on 4th sample of a symbol -> resync_err=1, next bit
//      formed from 8 samples starting at marked sample.
//   6) reset asserted after 5 samples -> outputs 0, samples ignored until
//      next sym_start; gaps in sample_valid do not change results.

Source files
------------

// File: rtl/bpsk_integrate_dump.sv
// Integrate-and-dump BPSK slicer: sums SAMPLES_PER_SYM channel samples per symbol and
// emits a hard decision on a 1-deep valid/ready register. Define IAD_SOFT_OUT_EN for soft_out.
module bpsk_integrate_dump #(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned SAMPLES_PER_SYM = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] signal_in,
    input  logic              sample_valid,
    input  logic              sym_start,
    input  logic              clear_err,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
`ifdef IAD_SOFT_OUT_EN
    output logic [DATA_W-1:0] soft_out,
`endif
    output logic              overflow_err,
    output logic              resync_err
);

    localparam int unsigned CNT_W = $clog2(SAMPLES_PER_SYM);
    localparam int unsigned ACC_W = DATA_W + CNT_W;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(SAMPLES_PER_SYM - 1);

    typedef enum logic {StWaitAlign, StIntegrate} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bit_q, bit_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic               rsy_q, rsy_d;
    logic [ACC_W-1:0]   sample_ext;
    logic [ACC_W-1:0]   sum;
    logic               dump;
`ifdef IAD_SOFT_OUT_EN
    logic [DATA_W-1:0]  soft_q, soft_d;
    logic [DATA_W-1:0]  sum_sat;
    logic [CNT_W:0]     sum_top;
`endif

    assign sample_ext = {{CNT_W{signal_in[DATA_W-1]}}, signal_in};
    assign sum        = acc_q + sample_ext;

`ifdef IAD_SOFT_OUT_EN
    // Sum fits DATA_W only when all bits above the DATA_W sign bit agree with it.
    assign sum_top = sum[ACC_W-1:DATA_W-1];
    always_comb begin
        sum_sat = sum[DATA_W-1:0];
        if (sum_top != '0 && sum_top != '1) begin
            sum_sat = sum[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        rsy_d   = rsy_q;
        dump    = 1'b0;
`ifdef IAD_SOFT_OUT_EN
        soft_d  = soft_q;
`endif
        if (clear_err) begin
            ovf_d = 1'b0;
            rsy_d = 1'b0;
        end

        unique case (state_q)
            StWaitAlign: begin
                if (sample_valid && sym_start) begin
                    acc_d   = sample_ext;
                    cnt_d   = CNT_W'(1);
                    state_d = StIntegrate;
                end
            end
            StIntegrate: begin
                if (sample_valid) begin
                    if (sym_start && cnt_q != '0) begin
                        rsy_d = 1'b1;
                        acc_d = sample_ext;
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == LastCnt) begin
                        dump  = 1'b1;
                        acc_d = '0;
                        cnt_d = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StWaitAlign;
        endcase

        // A decision arriving while the previous one is still unaccepted is lost.
        if (dump) begin
            if (!valid_q || bit_ready) begin
                valid_d = 1'b1;
                bit_d   = ~sum[ACC_W-1];
`ifdef IAD_SOFT_OUT_EN
                soft_d  = sum_sat;
`endif
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && bit_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWaitAlign;
            acc_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            rsy_q   <= 1'b0;
`ifdef IAD_SOFT_OUT_EN
            soft_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            rsy_q   <= rsy_d;
`ifdef IAD_SOFT_OUT_EN
            soft_q  <= soft_d;
`endif
        end
    end

    assign bit_out      = bit_q;
    assign bit_valid    = valid_q;
    assign overflow_err = ovf_q;
    assign resync_err   = rsy_q;
`ifdef IAD_SOFT_OUT_EN
    assign soft_out     = soft_q;
`endif

endmodule

// File: tb/tb_bpsk_integrate_dump.sv
// Bench for bpsk_integrate_dump: directed table, hand-written corner sequences and a
// randomized run against a queue-based symbol model. Honours IAD_SOFT_OUT_EN.
module tb_bpsk_integrate_dump;
    localparam int SPS = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] signal_in = '0;
    logic        sample_valid = 1'b0;
    logic        sym_start = 1'b0;
    logic        clear_err = 1'b0;
    logic        bit_ready = 1'b1;
    logic        bit_out, bit_valid, overflow_err, resync_err;
`ifdef IAD_SOFT_OUT_EN
    logic [15:0] soft_out;
`endif

    bpsk_integrate_dump #(.DATA_W(16), .SAMPLES_PER_SYM(SPS)) dut (
        .clk          (clk),
        .reset        (reset),
        .signal_in    (signal_in),
        .sample_valid (sample_valid),
        .sym_start    (sym_start),
        .clear_err    (clear_err),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
`ifdef IAD_SOFT_OUT_EN
        .soft_out     (soft_out),
`endif
        .overflow_err (overflow_err),
        .resync_err   (resync_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: samples of the current symbol, alignment flag, output register.
    int q[$];
    bit aligned = 0;
    bit m_valid = 0, m_bit = 0, m_ovf = 0, m_rsy = 0;
    int m_soft = 0;

    typedef struct {
        bit sv;
        bit ss;
        int d;
        bit rdy;
        int ev;
        int eb;
        int es;
    } vec_t;
    vec_t tbl[$];

    task automatic check(string name, input logic signed [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(bit rst, bit sv, bit ss, int d, bit rdy, bit clr);
        bit dump = 0;
        bit set_ovf = 0, set_rsy = 0;
        int s = 0;
        if (rst) begin
            q.delete();
            aligned = 0;
            m_valid = 0; m_bit = 0; m_ovf = 0; m_rsy = 0; m_soft = 0;
            return;
        end
        if (sv) begin
            if (!aligned) begin
                if (ss) begin
                    aligned = 1;
                    q.delete();
                    q.push_back(d);
                end
            end else begin
                if (ss && q.size() != 0) begin
                    set_rsy = 1;
                    q.delete();
                end
                q.push_back(d);
                if (q.size() == SPS) begin
                    foreach (q[k]) s += q[k];
                    dump = 1;
                    q.delete();
                end
            end
        end
        if (dump) begin
            if (!m_valid || rdy) begin
                m_valid = 1;
                m_bit   = (s >= 0);
                m_soft  = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
            end else begin
                set_ovf = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_ovf = set_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_rsy = set_rsy ? 1'b1 : (clr ? 1'b0 : m_rsy);
    endfunction

    task automatic cycle(bit sv, bit ss, int d, bit rdy, bit clr);
        sample_valid = sv;
        sym_start    = ss;
        signal_in    = 16'(d);
        bit_ready    = rdy;
        clear_err    = clr;
        @(posedge clk);
        model_step(reset, sv, ss, d, rdy, clr);
        #1;
        check("model_valid", bit_valid, m_valid);
        check("model_bit", bit_out, m_bit);
        check("model_ovf", overflow_err, m_ovf);
        check("model_rsy", resync_err, m_rsy);
`ifdef IAD_SOFT_OUT_EN
        check("model_soft", $signed(soft_out), m_soft);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(0, 0, 0, 1, 0);
        reset = 1'b0;
        check("rst_valid", bit_valid, 0);
        check("rst_bit", bit_out, 0);
        check("rst_ovf", overflow_err, 0);
        check("rst_rsy", resync_err, 0);
`ifdef IAD_SOFT_OUT_EN
        check("rst_soft", $signed(soft_out), 0);
`endif
    endtask

    task automatic sym(int v, bit first_ss, bit rdy);
        for (int i = 0; i < SPS; i++) cycle(1, first_ss && i == 0, v, rdy, 0);
    endtask

    function automatic void add(bit sv, bit ss, int d, bit rdy, int ev, int eb, int es);
        vec_t r;
        r.sv = sv; r.ss = ss; r.d = d; r.rdy = rdy; r.ev = ev; r.eb = eb; r.es = es;
        tbl.push_back(r);
    endfunction

    initial begin
        // +1000 symbol, -1000 symbol (no marker), zero-sum symbol, idle.
        for (int i = 0; i < SPS; i++) add(1, i == 0, 1000, 1, int'(i == SPS - 1), 1, 8000);
        add(0, 0, 0, 1, 0, 1, 8000);
        for (int i = 0; i < SPS; i++) add(1, 0, -1000, 1, int'(i == SPS - 1), 0, -8000);
        for (int i = 0; i < SPS; i++) add(1, 0, (i < 4) ? 500 : -500, 1, int'(i == SPS - 1), 1, 0);
        add(0, 0, 0, 1, 0, 1, 0);

        repeat (2) @(posedge clk);
        do_reset();
        foreach (tbl[k]) begin
            cycle(tbl[k].sv, tbl[k].ss, tbl[k].d, tbl[k].rdy, 0);
            check("tbl_valid", bit_valid, tbl[k].ev);
            if (tbl[k].ev != 0) begin
                check("tbl_bit", bit_out, tbl[k].eb);
`ifdef IAD_SOFT_OUT_EN
                check("tbl_soft", $signed(soft_out), tbl[k].es);
`endif
            end
        end

        // Full-scale symbols exercise soft saturation.
        do_reset();
        sym(32767, 1, 1);
        check("fs_pos_valid", bit_valid, 1);
        check("fs_pos_bit", bit_out, 1);
`ifdef IAD_SOFT_OUT_EN
        check("fs_pos_soft", $signed(soft_out), 32767);
`endif
        sym(-32768, 0, 1);
        check("fs_neg_bit", bit_out, 0);
`ifdef IAD_SOFT_OUT_EN
        check("fs_neg_soft", $signed(soft_out), -32768);
`endif

        // Backpressure: first bit held, later ones dropped, stickies.
        do_reset();
        sym(1000, 1, 0);
        check("bp_first_valid", bit_valid, 1);
        check("bp_first_bit", bit_out, 1);
        sym(-1000, 0, 0);
        check("bp_held_bit", bit_out, 1);
        check("bp_ovf_set", overflow_err, 1);
        cycle(0, 0, 0, 0, 1);
        check("bp_ovf_clr", overflow_err, 0);
        check("bp_still_valid", bit_valid, 1);
        for (int i = 0; i < SPS; i++) cycle(1, 0, -1000, 0, i == SPS - 1);
        check("bp_set_wins", overflow_err, 1);
        check("bp_held_bit2", bit_out, 1);
        cycle(0, 0, 0, 1, 0);
        check("bp_accepted", bit_valid, 0);

        // Marker mid-symbol discards partial sum.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, i == 0, -2000, 1, 0);
        for (int i = 0; i < SPS; i++) begin
            cycle(1, i == 0, 100, 1, 0);
            if (i == 0) check("rs_flag", resync_err, 1);
        end
        check("rs_valid", bit_valid, 1);
        check("rs_bit", bit_out, 1);
`ifdef IAD_SOFT_OUT_EN
        check("rs_soft", $signed(soft_out), 800);
`endif
        cycle(0, 0, 0, 1, 1);
        check("rs_clr", resync_err, 0);

        // Reset mid-symbol, unmarked samples ignored, gaps do not matter.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, i == 0, 1000, 1, 0);
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1, 0, -1000, 1, 0);
        check("ign_valid", bit_valid, 0);
        for (int i = 0; i < SPS; i++) begin
            cycle(0, i != 0, -30000, 1, 0);
            cycle(1, i == 0, -300, 1, 0);
        end
        check("gap_valid", bit_valid, 1);
        check("gap_bit", bit_out, 0);
        check("gap_rsy", resync_err, 0);

        // Randomized run against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic [15:0] r;
            bit ss;
            r  = 16'($urandom);
            ss = (q.size() == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 499) == 0);
            cycle($urandom_range(0, 9) < 7, ss, int'($signed(r)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0);
            reset = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
